// File: rtl/uart_pkt_framer.sv
// uart_pkt_framer: frames SYNC, LEN, FIFO payload and checksum onto a UART byte interface
module uart_pkt_framer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_LEN    = 16,
    parameter int                    LEN_W      = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5,
    parameter int                    CHK_MODE   = 0,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  fifo_empty,
    input  logic                  uart_busy,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  tx_start,
    output logic                  rd_en,
    output logic                  fsm_busy,
    output logic                  pkt_done,
    output logic                  pkt_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SYNC, LEN, TXW, FETCH, CAPT, CSUM, DONE} state_t;

    state_t                state_q, state_d, ret_q, ret_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d, d_out_q, d_out_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  tx_start_q, tx_start_d, rd_en_q, rd_en_d, fsm_busy_q, fsm_busy_d;
    logic                  pkt_done_q, pkt_done_d, pkt_err_q, pkt_err_d;

    function automatic logic [DATA_WIDTH-1:0] op(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        return (CHK_MODE == 1) ? a + b : a ^ b;
    endfunction

    // next-state and next-output logic; tx_start_q high marks the TXW guard cycle
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        rem_d      = rem_q;
        chk_d      = chk_q;
        d_out_d    = d_out_q;
        tmo_d      = tmo_q;
        tx_start_d = 1'b0;
        rd_en_d    = 1'b0;
        pkt_done_d = 1'b0;
        pkt_err_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (pkt_len != '0 && pkt_len <= LEN_W'(MAX_LEN)) begin
                    rem_d   = pkt_len;
                    chk_d   = '0;
                    tmo_d   = '0;
                    state_d = SYNC;
                end else pkt_err_d = 1'b1;
            end
            SYNC: begin
                d_out_d    = SYNC_BYTE;
                tx_start_d = 1'b1;
                ret_d      = LEN;
                state_d    = TXW;
            end
            LEN: begin
                d_out_d    = DATA_WIDTH'(rem_q);
                chk_d      = op(chk_q, DATA_WIDTH'(rem_q));
                tx_start_d = 1'b1;
                ret_d      = FETCH;
                state_d    = TXW;
            end
            TXW: state_d = (!tx_start_q && !uart_busy) ? ret_q : TXW;
            FETCH: if (!fifo_empty) begin
                rd_en_d = 1'b1;
                tmo_d   = '0;
                state_d = CAPT;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                tmo_d     = '0;
                pkt_err_d = 1'b1;
                state_d   = IDLE;
            end else tmo_d = tmo_q + 1'b1;
            CAPT: begin
                d_out_d    = d_in;
                chk_d      = op(chk_q, d_in);
                tx_start_d = 1'b1;
                rem_d      = rem_q - 1'b1;
                ret_d      = (rem_d != '0) ? FETCH : CSUM;
                state_d    = TXW;
            end
            CSUM: begin
                d_out_d    = chk_q;
                tx_start_d = 1'b1;
                ret_d      = DONE;
                state_d    = TXW;
            end
            DONE: begin
                pkt_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        fsm_busy_d = state_d != IDLE;
    end

    // register state, datapath and every output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            rem_q      <= '0;
            chk_q      <= '0;
            d_out_q    <= '0;
            tmo_q      <= '0;
            tx_start_q <= 1'b0;
            rd_en_q    <= 1'b0;
            fsm_busy_q <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            rem_q      <= rem_d;
            chk_q      <= chk_d;
            d_out_q    <= d_out_d;
            tmo_q      <= tmo_d;
            tx_start_q <= tx_start_d;
            rd_en_q    <= rd_en_d;
            fsm_busy_q <= fsm_busy_d;
            pkt_done_q <= pkt_done_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    assign d_out    = d_out_q;
    assign tx_start = tx_start_q;
    assign rd_en    = rd_en_q;
    assign fsm_busy = fsm_busy_q;
    assign pkt_done = pkt_done_q;
    assign pkt_err  = pkt_err_q;
endmodule

// File: tb/tb_uart_pkt_framer.sv
// tb_uart_pkt_framer: directed and random packets checked against a byte-stream reference model
module tb_uart_pkt_framer;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, fifo_empty = 1'b1, uart_busy = 1'b0;
    logic [7:0] pkt_len = 8'd0, d_in = 8'd0;
    logic [7:0] d_out0, d_out1;
    logic       tx0, tx1, rd0, rd1, busy0, busy1, done0, done1, err0, err1;
    int         tests = 0, fails = 0, cyc = 0, busy_len = 0, bcnt = 0;
    int         n_rd0 = 0, n_done = 0, n_err = 0, n_div = 0, done_cyc = 0, err_cyc = 0;
    logic [7:0] fq[$], pl[$], obs0[$], obs1[$], exp0[$], exp1[$];
    int         txc[$];

    uart_pkt_framer #(.CHK_MODE(0), .TIMEOUT(8)) u_xor (
        .clk(clk), .rst_n(rst_n), .start(start), .pkt_len(pkt_len), .d_in(d_in),
        .fifo_empty(fifo_empty), .uart_busy(uart_busy), .d_out(d_out0), .tx_start(tx0),
        .rd_en(rd0), .fsm_busy(busy0), .pkt_done(done0), .pkt_err(err0));

    uart_pkt_framer #(.CHK_MODE(1), .TIMEOUT(8)) u_sum (
        .clk(clk), .rst_n(rst_n), .start(start), .pkt_len(pkt_len), .d_in(d_in),
        .fifo_empty(fifo_empty), .uart_busy(uart_busy), .d_out(d_out1), .tx_start(tx1),
        .rd_en(rd1), .fsm_busy(busy1), .pkt_done(done1), .pkt_err(err1));

    always #5 clk = ~clk;

    // show-ahead FIFO pops on rd_en; cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd0 && fq.size() > 0) void'(fq.pop_front());
    end

    // FIFO flags/data and a UART that stays busy busy_len cycles after each strobe
    always @(negedge clk) begin
        fifo_empty = fq.size() == 0;
        d_in = fifo_empty ? 8'h00 : fq[0];
        bcnt = tx0 ? busy_len : (bcnt > 0 ? bcnt - 1 : 0);
        uart_busy = bcnt > 0;
    end

    // wire monitor
    always @(negedge clk) if (rst_n) begin
        if (tx0) begin obs0.push_back(d_out0); txc.push_back(cyc); end
        if (tx1) obs1.push_back(d_out1);
        if (rd0) n_rd0++;
        if (done0) begin n_done++; done_cyc = cyc; end
        if (err0) begin n_err++; err_cyc = cyc; end
        if ({tx0, rd0, busy0, done0, err0} !== {tx1, rd1, busy1, done1, err1}) n_div++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
        pl.delete(); fq.delete(); txc.delete();
        n_rd0 = 0; n_done = 0; n_err = 0; n_div = 0;
    endtask

    // reference: SYNC, LEN, sent payload, then checksum only for a complete packet
    task automatic add_pkt(input int len, input int nsent, input int off);
        logic [7:0] x;
        int s;
        x = 8'(len);
        s = len;
        exp0.push_back(8'hA5); exp1.push_back(8'hA5);
        exp0.push_back(8'(len)); exp1.push_back(8'(len));
        for (int i = 0; i < nsent; i++) begin
            exp0.push_back(pl[off + i]); exp1.push_back(pl[off + i]);
            x = x ^ pl[off + i];
            s = s + int'(pl[off + i]);
        end
        if (nsent == len) begin exp0.push_back(x); exp1.push_back(8'(s % 256)); end
    endtask

    task automatic wait_end(input string tag, input int n);
        int k = 0;
        while (n_done + n_err < n && k < 3000) begin @(posedge clk); k++; end
        check({tag, " end seen"}, k < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, " bytes xor"}, obs0.size(), exp0.size());
        check({tag, " bytes sum"}, obs1.size(), exp1.size());
        for (int i = 0; i < exp0.size() && i < obs0.size(); i++) check($sformatf("%s xor[%0d]", tag, i), obs0[i], exp0[i]);
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++) check($sformatf("%s sum[%0d]", tag, i), obs1[i], exp1[i]);
    endtask

    // payload must already be in pl; nf of those bytes go into the FIFO
    task automatic run_pkt(input string tag, input int len, input int bl);
        int nf, ns;
        nf = pl.size();
        ns = nf < len ? nf : len;
        busy_len = bl;
        foreach (pl[i]) fq.push_back(pl[i]);
        add_pkt(len, ns, 0);
        repeat (2) @(negedge clk);
        start = 1'b1; pkt_len = 8'(len);
        @(negedge clk);
        start = 1'b0; pkt_len = 8'($urandom);
        wait_end(tag, 1);
        cmp_stream(tag);
        check({tag, " rd_en count"}, n_rd0, ns);
        check({tag, " pkt_done count"}, n_done, nf < len ? 0 : 1);
        check({tag, " pkt_err count"}, n_err, nf < len ? 1 : 0);
        check({tag, " idle"}, busy0, 1'b0);
        check({tag, " dut ctrl agree"}, n_div, 0);
    endtask

    task automatic rand_pkt(input string tag, input int len, input int bl);
        clear();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        run_pkt(tag, len, bl);
    endtask

    initial begin
        int k, s0;
        int gaps[9] = '{3, 4, 4, 3, 5, 3, 4, 4, 3};
        #1;
        check("por outputs", {d_out0, tx0, rd0, busy0, done0, err0}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("por idle", {d_out0, tx0, rd0, busy0, done0, err0}, '0);

        // T1: reset mid-CAPT then a single-byte packet
        clear();
        busy_len = 2;
        for (int i = 0; i < 3; i++) fq.push_back(8'($urandom));
        repeat (2) @(negedge clk);
        start = 1'b1; pkt_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!rd0 && k < 200) begin @(negedge clk); k++; end
        check("T1 reached capt", k < 200, 1);
        rst_n = 1'b0;
        #1;
        check("T1 reset d_out", d_out0, 8'h00);
        check("T1 reset strobes", {tx0, rd0, busy0, done0, err0}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear();
        @(negedge clk);
        check("T1 post-reset idle", {d_out0, tx0, rd0, busy0, done0, err0}, '0);
        pl.push_back(8'($urandom));
        run_pkt("T1 len1", 1, 2);

        // T2: xor checksum, slow UART
        clear();
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        run_pkt("T2", 3, 5);
        check("T2 xor csum", obs0.size() > 5 ? obs0[5] : 8'hxx, 8'h03);

        // T3: additive checksum wraps
        clear();
        pl.push_back(8'hFF); pl.push_back(8'h02);
        run_pkt("T3", 2, 3);
        check("T3 sum csum", obs1.size() > 4 ? obs1[4] : 8'hxx, 8'h03);

        // T4: rejected lengths
        clear();
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            s0 = cyc;
            start = 1'b1; pkt_len = j == 0 ? 8'd0 : 8'd17;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            check($sformatf("T4 err latency %0d", j), err_cyc - s0, 1);
        end
        check("T4 err count", n_err, 2);
        check("T4 no tx", obs0.size(), 0);
        check("T4 no rd", n_rd0, 0);
        check("T4 idle", busy0, 1'b0);

        // T5: starvation timeout
        clear();
        pl.push_back(8'($urandom)); pl.push_back(8'($urandom));
        run_pkt("T5", 4, 0);
        check("T5 err timing", txc.size() > 0 ? err_cyc - txc[txc.size() - 1] : -1, 10);

        // T6: start held, idle UART, back-to-back packets
        clear();
        busy_len = 0;
        for (int i = 0; i < 4; i++) begin pl.push_back(8'($urandom)); fq.push_back(pl[i]); end
        add_pkt(2, 2, 0);
        add_pkt(2, 2, 2);
        repeat (2) @(negedge clk);
        s0 = cyc;
        start = 1'b1; pkt_len = 8'd2;
        k = 0;
        while (txc.size() < 6 && k < 200) begin @(posedge clk); k++; end
        check("T6 second sync seen", k < 200, 1);
        @(negedge clk);
        start = 1'b0;
        wait_end("T6", 2);
        cmp_stream("T6");
        check("T6 start latency", txc.size() > 0 ? txc[0] - s0 : -1, 2);
        for (int i = 0; i < 9; i++) check($sformatf("T6 gap %0d", i), txc.size() == 10 ? txc[i + 1] - txc[i] : -1, gaps[i]);
        check("T6 done timing", txc.size() == 10 ? done_cyc - txc[9] : -1, 3);
        check("T6 done count", n_done, 2);
        check("T6 rd count", n_rd0, 4);
        check("T6 dut ctrl agree", n_div, 0);

        // random packets including the longest legal length
        rand_pkt("max len", 16, 1);
        for (int r = 0; r < 6; r++) rand_pkt($sformatf("rand%0d", r), $urandom_range(1, 16), $urandom_range(0, 5));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
